slave_rx_fsm: RTL and testbench
===============================

SLAVE_RX_FSM -- requirements
Module: slave_rx_fsm

Interface
REQ-001 SHALL have parameter DEPTH, default 4, receive buffer entries; legal values 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port req, input, 1, master request of the four-phase req/ack link.
REQ-005 SHALL have port data_in, input, 8, byte presented by the master while req=1.
REQ-006 SHALL have port ack, output, 1, registered acknowledge to the master.
REQ-007 SHALL have port rd_en, input, 1, consumer pop request.
REQ-008 SHALL have port rd_data, output, 8, head buffer entry (first-word fall-through).
REQ-009 SHALL have port rd_valid, output, 1, high when buffer non-empty.
REQ-010 SHALL have port full, output, 1, high when buffer holds DEPTH entries.
REQ-011 SHALL have port level, output, 5, current entry count, 0..DEPTH.
REQ-012 SHALL have port byte_cnt, output, 8, total bytes accepted since reset.
REQ-013 SHALL have port last_byte, output, 8, most recently accepted byte.

Function
REQ-014 SHALL implement states IDLE, ACK_HI, ACK_LO.
REQ-015 IDLE: ack=0; if req=1 and full=0 at an edge, SHALL write data_in to buffer tail, update last_byte, increment byte_cnt, set ack=1, go to ACK_HI at that edge.
REQ-016 IDLE with req=1 and full=1 SHALL hold ack=0 and stay in IDLE (backpressure) until full deasserts.
REQ-017 ACK_HI: ack=1; on req=0, SHALL clear ack and go to ACK_LO; data_in ignored.
REQ-018 ACK_LO: ack=0 for exactly one cycle, no capture even if req=1; SHALL return to IDLE.
REQ-019 Latency: ack SHALL rise the cycle after the edge sampling req=1 (non-full), and fall the cycle after the edge sampling req=0.
REQ-020 Byte SHALL be visible on rd_data/rd_valid the cycle after capture when buffer was empty.
REQ-021 rd_en=1 with rd_valid=1 SHALL advance head; rd_en with buffer empty SHALL be ignored, no underflow.
REQ-022 Capture and pop in the same cycle SHALL leave level unchanged; full is sampled before the pop (no same-cycle write into a full buffer).
REQ-023 Buffer pointers SHALL wrap modulo DEPTH; byte_cnt SHALL wrap 255->0.
REQ-024 rd_data SHALL be 8'h00 when rd_valid=0.

Reset
REQ-025 rst_n=0 at an edge SHALL force state IDLE, ack=0, level=0, full=0, rd_valid=0, byte_cnt=0, last_byte=8'h00, pointers 0, buffer contents don't-care.
REQ-026 Reset mid-handshake SHALL drop ack next cycle; if req is still 1 after release, slave SHALL treat it as a new transfer and capture data_in.

Configuration
REQ-027 Macro SLAVE_CHECKSUM_EN defined: SHALL add output checksum[7:0], XOR of all accepted bytes since reset, updated at capture edge, reset to 8'h00.
REQ-028 Macro undefined: checksum port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Master sends A0,A1,A2,A3 with consumer rd_en=1 -> four ack pulses, rd_data sequence A0..A3, byte_cnt=4, last_byte=A3.
REQ-030 rd_en=0, master sends 5 bytes with DEPTH=4 -> full=1 after 4th, ack stays 0 on 5th; one pop -> 5th byte captured, ack rises next cycle.
REQ-031 Master holds req=1 after ack -> ack stays 1, no second capture, byte_cnt unchanged.
REQ-032 rst_n=0 while ack=1 and level=2 -> next cycle ack=0, level=0, rd_valid=0, byte_cnt=0.
REQ-033 SLAVE_CHECKSUM_EN defined, bytes A0,A1,A2,A3 -> checksum=8'h00; bytes A0,A1 -> 8'h01.
REQ-034 256 transfers with continuous pop -> byte_cnt wraps to 0, no data loss or reordering.

Source files
------------

// File: rtl/slave_rx_fsm.sv
// Four-phase req/ack receiver feeding a first-word fall-through byte buffer.
// Optional XOR checksum output enabled by defining SLAVE_CHECKSUM_EN.
module slave_rx_fsm #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] data_in,
  output logic       ack,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       full,
  output logic [4:0] level,
  output logic [7:0] byte_cnt,
  output logic [7:0] last_byte
`ifdef SLAVE_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACK_HI,
    ACK_LO
  } state_t;

  state_t state, state_nx;

  logic          cap;
  logic          pop;
  logic          ack_nx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [7:0]    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      state <= state_nx;
      ack   <= ack_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cap) state_nx = ACK_HI;
      ACK_HI:  if (!req) state_nx = ACK_LO;
      ACK_LO:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Full is the registered count, so a same-edge pop cannot admit a write.
  always_comb begin
    cap    = (state == IDLE) && req && !full;
    ack_nx = (state_nx == ACK_HI);
  end

  assign pop      = rd_en && rd_valid;
  assign full     = (count == DEPTH_L);
  assign rd_valid = (count != 5'd0);
  assign level    = count;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 5'd0;
      byte_cnt  <= 8'h00;
      last_byte <= 8'h00;
    end else begin
      if (cap) begin
        wr_ptr    <= wr_ptr + AW'(1);
        byte_cnt  <= byte_cnt + 8'd1;
        last_byte <= data_in;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({cap, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SLAVE_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) checksum <= 8'h00;
    else if (cap) checksum <= checksum ^ data_in;
  end
`endif

endmodule

// File: tb/tb_slave_rx_fsm.sv
// Randomised bench for slave_rx_fsm against a queue-based reference model.
// Directed scenarios pin the model with hand-computed literal values.
module tb_slave_rx_fsm;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] data_in;
  logic       ack;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [4:0] level;
  logic [7:0] byte_cnt;
  logic [7:0] last_byte;
`ifdef SLAVE_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  slave_rx_fsm #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data_in(data_in),
    .ack(ack),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .level(level),
    .byte_cnt(byte_cnt),
    .last_byte(last_byte)
`ifdef SLAVE_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: buffer as a queue, handshake as two flags.
  logic [7:0] q[$];
  logic [7:0] popped[$];
  bit         m_ack, m_cool, m_live, mc, mp;
  logic [7:0] m_cnt, m_last, m_cks;
  int         ack_rises = 0;
  bit         ack_prev = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ack  = 1'b0;
      m_cool = 1'b0;
      m_cnt  = 8'h00;
      m_last = 8'h00;
      m_cks  = 8'h00;
      m_live = 1'b1;
    end else if (m_live) begin
      if (rd_en && rd_valid) popped.push_back(rd_data);
      mc = !m_ack && !m_cool && req && (q.size() < DEPTH);
      mp = rd_en && (q.size() > 0);
      if (mp) void'(q.pop_front());
      if (mc) begin
        q.push_back(data_in);
        m_cnt  = m_cnt + 8'd1;
        m_last = data_in;
        m_cks  = m_cks ^ data_in;
      end
      m_cool = m_ack && !req;
      m_ack  = m_ack ? req : mc;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("ack", int'(ack), int'(m_ack));
      chk("rd_valid", int'(rd_valid), int'(q.size() > 0));
      chk("rd_data", int'(rd_data), q.size() > 0 ? int'(q[0]) : 0);
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("level", int'(level), q.size());
      chk("byte_cnt", int'(byte_cnt), int'(m_cnt));
      chk("last_byte", int'(last_byte), int'(m_last));
`ifdef SLAVE_CHECKSUM_EN
      chk("checksum", int'(checksum), int'(m_cks));
`endif
      if (ack && !ack_prev) ack_rises++;
      ack_prev = ack;
    end
  end

  task automatic wait_ack(input logic v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack == v) return;
    end
    chk("ack_timeout", int'(ack), int'(v));
  endtask

  task automatic send(input logic [7:0] b);
    req     = 1'b1;
    data_in = b;
    wait_ack(1'b1);
    req     = 1'b0;
    data_in = 8'($urandom);
    wait_ack(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pct;
  int bad;
  int r0;

  initial begin
    rst_n   = 1'b0;
    req     = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_cnt", int'(byte_cnt), 0);
    chk("rst_last", int'(last_byte), 0);
    chk("rst_data", int'(rd_data), 0);
    rst_n = 1'b1;

    // Four bytes streamed through with the consumer always popping
    rd_en = 1'b1;
    popped.delete();
    r0 = ack_rises;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    repeat (3) @(negedge clk);
    chk("seq_acks", ack_rises - r0, 4);
    chk("seq_npop", popped.size(), 4);
    for (int i = 0; i < popped.size() && i < 4; i++)
      chk("seq_data", int'(popped[i]), 'hA0 + i);
    chk("seq_cnt", int'(byte_cnt), 4);
    chk("seq_last", int'(last_byte), 'hA3);
`ifdef SLAVE_CHECKSUM_EN
    chk("cks_4", int'(checksum), 'h00);
    do_reset();
    send(8'hA0);
    send(8'hA1);
    chk("cks_2", int'(checksum), 'h01);
`endif

    // Backpressure on a full buffer, released by one pop
    do_reset();
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
    chk("bp_full", int'(full), 1);
    chk("bp_level", int'(level), 4);
    req     = 1'b1;
    data_in = 8'hB4;
    repeat (5) @(negedge clk);
    chk("bp_ack_low", int'(ack), 0);
    chk("bp_cnt", int'(byte_cnt), 4);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("bp_ack_pop", int'(ack), 0);
    @(negedge clk);
    chk("bp_ack_rise", int'(ack), 1);
    chk("bp_last", int'(last_byte), 'hB4);
    chk("bp_cnt5", int'(byte_cnt), 5);
    req = 1'b0;
    wait_ack(1'b0);

    // Master holding req after ack must not cause a second capture
    rd_en = 1'b1;
    repeat (6) @(negedge clk);
    rd_en   = 1'b0;
    req     = 1'b1;
    data_in = 8'hC5;
    wait_ack(1'b1);
    for (int i = 0; i < 6; i++) begin
      data_in = 8'($urandom);
      @(negedge clk);
    end
    chk("hold_ack", int'(ack), 1);
    chk("hold_cnt", int'(byte_cnt), 6);
    chk("hold_last", int'(last_byte), 'hC5);
    req = 1'b0;
    wait_ack(1'b0);

    // Reset mid-handshake, then req still high is a fresh transfer
    do_reset();
    send(8'hD0);
    req     = 1'b1;
    data_in = 8'hD1;
    wait_ack(1'b1);
    chk("mid_level", int'(level), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_ack", int'(ack), 0);
    chk("mid_level0", int'(level), 0);
    chk("mid_valid", int'(rd_valid), 0);
    chk("mid_cnt", int'(byte_cnt), 0);
    rst_n   = 1'b1;
    data_in = 8'hD2;
    @(negedge clk);
    chk("mid_recap", int'(ack), 1);
    chk("mid_cnt1", int'(byte_cnt), 1);
    chk("mid_last", int'(last_byte), 'hD2);
    chk("mid_head", int'(rd_data), 'hD2);
    req = 1'b0;
    wait_ack(1'b0);

    // Random master, consumer and occasional reset
    do_reset();
    pct = 50;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (n % 500 == 0) pct = (n / 500) % 3 == 0 ? 10 : ((n / 500) % 3 == 1 ? 50 : 90);
      rd_en = ($urandom % 100) < pct;
      rst_n = ($urandom % 1000) != 0;
      if (req && ack && ($urandom % 3 == 0)) req = 1'b0;
      else if (!req && ($urandom % 2 == 0)) begin
        req     = 1'b1;
        data_in = 8'($urandom);
      end else if (req && ack) data_in = 8'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;

    // 256 transfers wrap byte_cnt with no loss or reordering
    do_reset();
    rd_en = 1'b1;
    popped.delete();
    for (int i = 0; i < 256; i++) send(8'(i));
    repeat (3) @(negedge clk);
    chk("wrap_cnt", int'(byte_cnt), 0);
    chk("wrap_last", int'(last_byte), 'hFF);
    chk("wrap_npop", popped.size(), 256);
    bad = 0;
    for (int i = 0; i < popped.size() && i < 256; i++)
      if (popped[i] != 8'(i)) bad++;
    chk("wrap_order", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
